// File: rtl/rr_port_arbiter.sv
// Round-robin, burst-locking arbiter for one switch output port.
// A lane that starts a multi-beat burst keeps the port until its last beat or until MAX_BURST beats.
module rr_port_arbiter #(
    parameter int NUB       = 3,
    parameter int WIDTH     = 3,
    parameter int MAX_BURST = 8,
    localparam int IDX_W    = (NUB > 1) ? $clog2(NUB) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUB-1:0]       req_valid,
    input  logic [NUB-1:0]       req_last,
    input  logic [WIDTH*NUB-1:0] req_data,
    output logic [NUB-1:0]       req_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [NUB-1:0]       out_sel,
    output logic [IDX_W-1:0]     out_idx,
    output logic                 out_trunc
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t             state, state_nx;
    logic [IDX_W-1:0]   ptr, ptr_nx;
    logic [IDX_W-1:0]   owner, owner_nx;
    logic [CNT_W-1:0]   count, count_nx;
    logic [IDX_W-1:0]   win;
    logic [IDX_W-1:0]   cand;
    logic               found;
    logic               trunc;
    logic [NUB-1:0]     grant;

    function automatic logic [IDX_W-1:0] next_lane(input logic [IDX_W-1:0] lane);
        return IDX_W'((int'(lane) + 1) % NUB);
    endfunction

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        owner_nx = owner;
        count_nx = count;
        win      = '0;
        cand     = '0;
        found    = 1'b0;
        trunc    = 1'b0;
        case (state)
            IDLE: begin
                // Scan from ptr upward with wrap; first valid lane wins.
                for (int k = 0; k < NUB; k++) begin
                    cand = IDX_W'((int'(ptr) + k) % NUB);
                    if (!found && req_valid[cand]) begin
                        found = 1'b1;
                        win   = cand;
                    end
                end
                if (found) begin
                    if (req_last[win] || MAX_BURST == 1) begin
                        ptr_nx = next_lane(win);
                    end else begin
                        state_nx = LOCKED;
                        owner_nx = win;
                        count_nx = CNT_W'(1);
                    end
                end
            end
            LOCKED: begin
                win   = owner;
                found = req_valid[owner];
                if (found) begin
                    if (req_last[owner]) begin
                        state_nx = IDLE;
                        ptr_nx   = next_lane(owner);
                    end else if (count == CNT_W'(MAX_BURST - 1)) begin
                        state_nx = IDLE;
                        ptr_nx   = next_lane(owner);
                        trunc    = 1'b1;
                    end else begin
                        count_nx = count + CNT_W'(1);
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign grant     = NUB'(found) << win;
    assign req_ready = rst ? '0 : grant;

    // Winner data and index are only refreshed on an accepted beat; otherwise they hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            out_idx   <= '0;
            out_trunc <= 1'b0;
        end else begin
            state     <= state_nx;
            ptr       <= ptr_nx;
            owner     <= owner_nx;
            count     <= count_nx;
            out_valid <= found;
            out_sel   <= grant;
            out_trunc <= trunc;
            if (found) begin
                out_data <= req_data[int'(win)*WIDTH +: WIDTH];
                out_idx  <= win;
            end
        end
    end

endmodule
